avalon_mem_responder: RTL and testbench

- Avalon-MM slave for the 16-bit pipelined-read bus that our SDRAM/on-chip masters drive: active-low read_n/write_n, chipselect, waitrequest and readdatavalid.
- Owns an internal word-addressed RAM. Returns reads in order at a fixed latency and caps the number of outstanding reads.
- Supports an externally forced stall, so masters can be exercised against a realistic memory model in simulation and on the board.

---
 rtl/avalon_mem_responder.sv | 174 +++++++++++++++++
 tb/tb_avalon_mem_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_responder.sv
// avalon_mem_responder
//   Avalon-MM slave backed by an internal 16-bit word-addressed RAM.
//   Reads are pipelined with a fixed latency and returned strictly in order.
//   The number of reads still waiting to be returned is capped. An external
//   stall input forces waitrequest so masters can be tested against a slow
//   memory.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   chipselect     slave selected
//   read_n         active-low read request
//   write_n        active-low write request
//   address        word address (ADDR_W bits)
//   byteenable     write lane enables, [0] = bits 7:0, [1] = bits 15:8
//   writedata      write data
//   stall          forces waitrequest while a request is presented
//   waitrequest    request not accepted this cycle (combinational)
//   readdata       read return data, holds last returned value
//   readdatavalid  one cycle per accepted read, READ_LATENCY after accept
//   proto_err      sticky, read_n and write_n both low with chipselect high
//   rd_count       accepted reads, wraps
//   wr_count       accepted writes, wraps

module avalon_mem_responder #(
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        byteenable,
  input  logic [15:0]       writedata,
  input  logic              stall,
  output logic              waitrequest,
  output logic [15:0]       readdata,
  output logic              readdatavalid,
  output logic              proto_err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int                IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH);
  localparam logic [2:0]        PEND_MAX    = 3'(MAX_PENDING);

  logic [15:0]      mem [DEPTH];

  logic             req_rd;
  logic             req_wr;
  logic             req_both;
  logic             rd_accept;
  logic             wr_accept;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [15:0]      rd_word;
  logic [2:0]       pending_q;
  logic             launch;
  logic [15:0]      launch_data;

  // ---------------------------------------------------------------------------
  // Request decode and handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    req_rd   = chipselect & ~read_n & write_n;
    req_wr   = chipselect & ~write_n & read_n;
    req_both = chipselect & ~read_n & ~write_n;

    waitrequest = (req_rd | req_wr) &
                  (stall | (req_rd & (pending_q == PEND_MAX)));

    rd_accept = req_rd & ~waitrequest;
    wr_accept = req_wr & ~waitrequest;

    in_range = (address < DEPTH_LIMIT);
    idx      = address[IDX_W-1:0];
    rd_word  = in_range ? mem[idx] : 16'h0000;
  end

  // ---------------------------------------------------------------------------
  // RAM: byte-lane writes, never reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_accept && in_range) begin
      if (byteenable[0]) mem[idx][7:0]  <= writedata[7:0];
      if (byteenable[1]) mem[idx][15:8] <= writedata[15:8];
    end
  end

  // ---------------------------------------------------------------------------
  // Read return pipeline. The readdata/readdatavalid registers form the final
  // stage; "launch" is the input to that stage, i.e. a return that becomes
  // visible on the next cycle.
  // ---------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign launch      = rd_accept;
      assign launch_data = rd_word;
    end else begin : g_latn
      logic [READ_LATENCY-2:0] v_q;
      logic [15:0]             d_q [READ_LATENCY-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          v_q <= '0;
        end else begin
          v_q[0] <= rd_accept;
          for (int i = 1; i < READ_LATENCY - 1; i++) begin
            v_q[i] <= v_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        d_q[0] <= rd_word;
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          d_q[i] <= d_q[i-1];
        end
      end

      assign launch      = v_q[READ_LATENCY-2];
      assign launch_data = d_q[READ_LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      readdatavalid <= 1'b0;
      readdata      <= 16'h0000;
    end else begin
      readdatavalid <= launch;
      if (launch) readdata <= launch_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding-read counter. A read stops counting on the edge that sets
  // readdatavalid, so its slot is free in the same cycle the data is shown.
  // This lets MAX_PENDING == READ_LATENCY stream one read per cycle and
  // MAX_PENDING == 1 accept every other cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 3'd0;
    end else begin
      unique case ({rd_accept, launch})
        2'b10:   if (pending_q != PEND_MAX) pending_q <= pending_q + 3'd1;
        2'b01:   if (pending_q != 3'd0)     pending_q <= pending_q - 3'd1;
        default: pending_q <= pending_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status: sticky protocol error and wrapping transaction counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
      rd_count  <= 16'h0000;
      wr_count  <= 16'h0000;
    end else begin
      if (req_both)  proto_err <= 1'b1;
      if (rd_accept) rd_count  <= rd_count + 16'd1;
      if (wr_accept) wr_count  <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Scoreboard bench for avalon_mem_responder.
// Two instances share the stimulus bus: dut0 (MAX_PENDING=2) and dut1
// (MAX_PENDING=1). "sel" routes chipselect to one of them and muxes its
// outputs back, so the same driver tasks and monitor serve both.
module tb_avalon_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic        stall = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] address = '0;
  logic [1:0]  byteenable = '0;
  logic [15:0] writedata = '0;

  logic        wr0, wr1, rdv0, rdv1, perr0, perr1;
  logic [15:0] rdata0, rdata1, rdc0, rdc1, wrc0, wrc1;

  logic        waitrequest, readdatavalid, proto_err;
  logic [15:0] readdata, rd_count, wr_count;

  assign waitrequest   = sel ? wr1    : wr0;
  assign readdatavalid = sel ? rdv1   : rdv0;
  assign readdata      = sel ? rdata1 : rdata0;
  assign proto_err     = sel ? perr1  : perr0;
  assign rd_count      = sel ? rdc1   : rdc0;
  assign wr_count      = sel ? wrc1   : wrc0;

  avalon_mem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .READ_LATENCY(LAT), .MAX_PENDING(2)) dut0 (
    .clk(clk), .reset(reset), .chipselect(chipselect & ~sel), .read_n(read_n),
    .write_n(write_n), .address(address), .byteenable(byteenable), .writedata(writedata),
    .stall(stall), .waitrequest(wr0), .readdata(rdata0), .readdatavalid(rdv0),
    .proto_err(perr0), .rd_count(rdc0), .wr_count(wrc0));

  avalon_mem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .READ_LATENCY(LAT), .MAX_PENDING(1)) dut1 (
    .clk(clk), .reset(reset), .chipselect(chipselect & sel), .read_n(read_n),
    .write_n(write_n), .address(address), .byteenable(byteenable), .writedata(writedata),
    .stall(stall), .waitrequest(wr1), .readdata(rdata1), .readdatavalid(rdv1),
    .proto_err(perr1), .rd_count(rdc1), .wr_count(wrc1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every readdatavalid pops the oldest expected return
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      check("rdv_missing", 32'(cyc), 32'(e.due));
    end
    if (readdatavalid) begin
      if (sb.size() == 0) begin
        check("rdv_unexpected", 32'(readdatavalid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rd_data", 32'(readdata), 32'(e.data));
        check("rd_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic req(input bit is_wr, input logic [31:0] a, input logic [1:0] be,
                     input logic [15:0] wd, input logic [15:0] exp, input int n_stall,
                     output int waits);
    bit ok;
    @(negedge clk);
    chipselect = 1'b1;
    read_n     = is_wr;
    write_n    = !is_wr;
    address    = a;
    byteenable = be;
    writedata  = wd;
    waits      = 0;
    ok         = 1'b0;
    for (int k = 0; k < 40; k++) begin
      stall = (waits < n_stall);
      #1;
      if (!waitrequest) begin
        ok = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 32'(waitrequest), 32'd0);
    end else begin
      if (!is_wr) sb.push_back('{exp, cyc + LAT});
      @(posedge clk);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] be, input logic [15:0] wd);
    int w;
    req(1'b1, a, be, wd, 16'h0000, 0, w);
  endtask

  task automatic rd(input logic [31:0] a, input logic [15:0] exp, input int exp_waits);
    int w;
    req(1'b0, a, 2'b00, 16'h0000, exp, 0, w);
    check("rd_waits", 32'(w), 32'(exp_waits));
  endtask

  task automatic idle();
    @(negedge clk);
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    stall      = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    check("drain_left", 32'(sb.size()), 32'd0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;

    // reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check("rst_rd_count", 32'(rd_count), 32'h0);
    check("rst_wr_count", 32'(wr_count), 32'h0);
    check("rst_proto_err", 32'(proto_err), 32'h0);
    check("rst_rdv", 32'(readdatavalid), 32'h0);
    check("rst_readdata", 32'(readdata), 32'h0);
    check("rst_waitreq", 32'(waitrequest), 32'h0);

    // basic write then read, latency checked by the monitor
    wr(5, 2'b11, 16'hBEEF);
    rd(5, 16'hBEEF, 0);
    idle();
    drain();
    check("t1_wr_count", 32'(wr_count), 32'd1);
    check("t1_rd_count", 32'(rd_count), 32'd1);
    check("t1_hold", 32'(readdata), 32'hBEEF);

    // byte lanes, read-after-write, back-to-back reads with zero bubbles
    wr(5, 2'b01, 16'h1234);
    wr(6, 2'b11, 16'h0000);
    wr(6, 2'b10, 16'hAB00);
    rd(6, 16'hAB00, 0);
    rd(5, 16'hBE34, 0);
    rd(5, 16'hBE34, 0);
    rd(6, 16'hAB00, 0);
    rd(5, 16'hBE34, 0);
    idle();
    drain();
    check("t2_wr_count", 32'(wr_count), 32'd4);
    check("t2_rd_count", 32'(rd_count), 32'd6);

    // stalled write, then stall raised mid-burst of reads
    wr(7, 2'b11, 16'h1111);
    rd(7, 16'h1111, 0);
    idle();
    drain();
    req(1'b1, 7, 2'b11, 16'h7777, 16'h0000, 3, w);
    check("stall_wr_waits", 32'(w), 32'd3);
    idle();
    #1;
    check("stall_wr_count", 32'(wr_count), 32'd6);
    rd(7, 16'h7777, 0);
    rd(5, 16'hBE34, 0);
    req(1'b0, 6, 2'b00, 16'h0000, 16'hAB00, 2, w);
    check("stall_rd_waits", 32'(w), 32'd2);
    idle();
    drain();
    check("t3_rd_count", 32'(rd_count), 32'd10);

    // out-of-range accesses must not alias into the RAM
    wr(3, 2'b11, 16'h3333);
    rd(DEPTH + 3, 16'h0000, 0);
    wr(DEPTH + 3, 2'b11, 16'hFFFF);
    rd(DEPTH + 3, 16'h0000, 0);
    rd(3, 16'h3333, 0);
    idle();
    drain();
    check("t4_wr_count", 32'(wr_count), 32'd8);
    check("t4_rd_count", 32'(rd_count), 32'd13);
    check("t4_proto_err", 32'(proto_err), 32'h0);

    // read_n and write_n both low: no-op, sticky error
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
    address = 5; byteenable = 2'b11; writedata = 16'hDEAD;
    #1;
    check("both_waitreq", 32'(waitrequest), 32'h0);
    idle();
    #1;
    check("both_proto_err", 32'(proto_err), 32'h1);
    check("both_wr_count", 32'(wr_count), 32'd8);
    check("both_rd_count", 32'(rd_count), 32'd13);
    rd(5, 16'hBE34, 0);
    idle();
    drain();
    check("both_sticky", 32'(proto_err), 32'h1);

    // reset with two reads in flight
    rd(5, 16'hBE34, 0);
    rd(6, 16'hAB00, 0);
    #1;
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check("rst_flight_rdv", 32'(readdatavalid), 32'h0);
    end
    check("rst2_proto_err", 32'(proto_err), 32'h0);
    check("rst2_rd_count", 32'(rd_count), 32'h0);
    check("rst2_wr_count", 32'(wr_count), 32'h0);
    check("rst2_readdata", 32'(readdata), 32'h0);
    rd(5, 16'hBE34, 0);
    rd(7, 16'h7777, 0);
    idle();
    drain();
    check("rst2_rd_after", 32'(rd_count), 32'd2);
    check("rst2_hold", 32'(readdata), 32'h7777);

    // MAX_PENDING=1 instance: held read_n gives one accept every other cycle
    sel = 1'b1;
    for (int i = 0; i < 4; i++) wr(i, 2'b11, 16'h0A00 + 16'(i));
    for (int i = 0; i < 4; i++) rd(i, 16'h0A00 + 16'(i), (i == 0) ? 0 : 1);
    idle();
    drain();
    check("mp1_rd_count", 32'(rd_count), 32'd4);
    check("mp1_wr_count", 32'(wr_count), 32'd4);
    sel = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
